// File: rtl/lfsr_pkg.sv
// Shared constants and types for the LFSR family: maximal-length tap masks
// and the generator's FSM encoding.
package lfsr_pkg;

    localparam logic [3:0]  TAPS_4  = 4'b1100;
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;
    localparam logic [31:0] TAPS_32 = 32'h80200003;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fsm_t;

endpackage

// File: rtl/lfsr_next.sv
// Fibonacci LFSR next-state function: shift left, XOR of tapped bits into bit 0.
// Purely combinational so scramblers can reuse it.
module lfsr_next #(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = 4'b1100
) (
    input  logic [WIDTH-1:0] state,
    output logic [WIDTH-1:0] next
);

    assign next = {state[WIDTH-2:0], ^(state & TAPS)};

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR source with seed load, zero-seed protection, valid/ready
// output stream and period measurement against the last loaded seed.
module lfsr_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH = 4,
    parameter logic [WIDTH-1:0] TAPS  = TAPS_4,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out,
    output logic             wrap,
    output logic [WIDTH-1:0] period,
    output logic             lockup_err
);

    fsm_t             fsm, fsm_nxt;
    logic [WIDTH-1:0] state, state_nxt;
    logic [WIDTH-1:0] ref_seed, ref_seed_nxt;
    logic [WIDTH-1:0] step_cnt, step_cnt_nxt;
    logic [WIDTH-1:0] period_nxt;
    logic             wrap_nxt;
    logic             lockup_nxt;
    logic [WIDTH-1:0] lfsr_step;
    logic             handshake;

    lfsr_next #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next (
        .state (state),
        .next  (lfsr_step)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            fsm        <= IDLE;
            state      <= SEED;
            ref_seed   <= SEED;
            step_cnt   <= '0;
            period     <= '0;
            wrap       <= 1'b0;
            lockup_err <= 1'b0;
        end else begin
            fsm        <= fsm_nxt;
            state      <= state_nxt;
            ref_seed   <= ref_seed_nxt;
            step_cnt   <= step_cnt_nxt;
            period     <= period_nxt;
            wrap       <= wrap_nxt;
            lockup_err <= lockup_nxt;
        end
    end

    // Load outranks the handshake: a word accepted in the same cycle is
    // dropped, and a zero seed falls back to SEED so the state never locks up.
    always_comb begin
        fsm_nxt      = fsm;
        state_nxt    = state;
        ref_seed_nxt = ref_seed;
        step_cnt_nxt = step_cnt;
        period_nxt   = period;
        wrap_nxt     = 1'b0;
        lockup_nxt   = 1'b0;
        if (load) begin
            fsm_nxt      = IDLE;
            step_cnt_nxt = '0;
            period_nxt   = '0;
            if (seed_in != '0) begin
                state_nxt    = seed_in;
                ref_seed_nxt = seed_in;
            end else begin
                state_nxt    = SEED;
                ref_seed_nxt = SEED;
                lockup_nxt   = 1'b1;
            end
        end else begin
            case (fsm)
                IDLE: begin
                    if (en) begin
                        fsm_nxt = RUN;
                    end
                end
                RUN: begin
                    if (handshake) begin
                        state_nxt = lfsr_step;
                        if (lfsr_step == ref_seed) begin
                            wrap_nxt     = 1'b1;
                            period_nxt   = step_cnt + WIDTH'(1);
                            step_cnt_nxt = '0;
                        end else begin
                            step_cnt_nxt = step_cnt + WIDTH'(1);
                        end
                        if (!en) begin
                            fsm_nxt = IDLE;
                        end
                    end
                end
                default: fsm_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        out_valid = (fsm == RUN);
        out       = state;
        handshake = out_valid & out_ready;
    end

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
- Parametrised Fibonacci LFSR pseudo-random source; the next-generation replacement for the fixed 4-bit LFSR.
- Adds configurable width, taps and reset seed, a runtime seed load, and a valid/ready output stream.
- Also adds all-zero lock-up protection and period measurement (wrap pulse plus step count).
- Feeds test-pattern generators and scramblers on the lab boards.

Parameters:
- WIDTH, 4, state and output width in bits; legal range 3..32.
- TAPS, 4'b1100, feedback mask of WIDTH bits; feedback bit = XOR of state bits where TAPS=1.
- SEED, 4'b0001, WIDTH-bit state after reset and fallback for an illegal zero load; must be non-zero.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous reset, active-high.
- en  in  1  request generation; sampled each cycle.
- load  in  1  load seed_in into the state this cycle.
- seed_in  in  WIDTH  runtime seed.
- out_ready  in  1  consumer accepts the current word.
- out_valid  out  1  out holds a valid word.
- out  out  WIDTH  current LFSR state.
- wrap  out  1  one-cycle pulse when the state returns to the reference seed.
- period  out  WIDTH  step count of the last completed cycle.
- lockup_err  out  1  one-cycle pulse when a zero seed_in is rejected.

Behaviour:
- Next-state function: next = {state[WIDTH-2:0], ^(state & TAPS)} (shift left, feedback into bit 0).
- Reset (RST=1, synchronous):
  - state=SEED, ref_seed=SEED, out_valid=0, wrap=0, period=0, lockup_err=0, step_cnt=0; FSM goes to IDLE.
  - RST overrides every other input.
- FSM, two states:
  - IDLE: out_valid=0. If en=1, go to RUN and assert out_valid from the next cycle. The first word is the current state, with no advance.
  - RUN: out_valid=1. Handshake = out_valid & out_ready.
    - On handshake: state<=next; step_cnt increments; out_valid stays 1 if en=1, otherwise go to IDLE.
    - Without handshake: out and out_valid stay stable regardless of en. Once asserted, out_valid is never withdrawn except by load or RST.
- Latency: one cycle from en rising in IDLE to out_valid=1. With out_ready held high, there is one new word per cycle.
- Load (load=1, lower priority than RST, higher than handshake):
  - If seed_in!=0: state<=seed_in and ref_seed<=seed_in.
  - If seed_in==0: state<=SEED and ref_seed<=SEED, and lockup_err pulses the next cycle.
  - In both cases: step_cnt<=0, out_valid<=0, FSM goes to IDLE. A handshake in the same cycle is discarded, and the consumer must not count it.
- Wrap/period:
  - On a handshake where next==ref_seed: wrap=1 the following cycle; period<=step_cnt+1; step_cnt<=0.
  - period holds until the next wrap, load or RST.
  - step_cnt never exceeds 2^WIDTH-2, because a non-zero state always cycles back.
- The all-zero state is unreachable: reset and load both guarantee a non-zero state, and the next-state function preserves non-zero.
- Simultaneous load and en: load wins. The FSM stays in IDLE this cycle and en is evaluated again the next cycle.

Decomposition:
- Shared package lfsr_pkg:
  - Maximal-length tap constants: TAPS_4=4'b1100, TAPS_8=8'hB8, TAPS_16=16'hB400, TAPS_32=32'h80200003.
  - FSM state encoding: IDLE=0, RUN=1.
- One combinational sub-module, lfsr_next (WIDTH, TAPS): state in, next out. It is reused by scrambler blocks.

Test Plan:
- Reset then en=1, out_ready=1, defaults -> out_valid rises one cycle after en. out sequence: 0001, 0010, 0100, 1001, 0011, 0110, 1101, 1010, 0101, 1011, 0111, 1111, 1110, 1100, 1000, then 0001 again. wrap pulses once, period=15, lockup_err never fires.
- Backpressure: out_ready=0 for 5 cycles while valid with out=0100 -> out stays 0100 and out_valid stays 1 even if en drops. After one handshake with en=0, out_valid=0 and state=1001.
- load=1, seed_in=4'b1010 mid-stream -> next cycle out=1010, out_valid=0. Eventually wrap fires when the state returns to 1010, with period=15.
- load=1, seed_in=0 -> out=0001, lockup_err high exactly one cycle, step_cnt cleared.
- RST=1 asserted mid-stream while load=1 and a handshake are also active -> next cycle state=0001, out_valid=0, period=0. No wrap or lockup_err pulse.
- WIDTH=8, TAPS=8'hB8, SEED=8'h01, free-running -> wrap after 255 handshakes, period=255. No state equals 0 at any time.
